// File: rtl/punc_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// punc_mem_arb_pkg
// Shared types and constants for the PUnC unified-memory arbiter.
//   - arb_state_e : arbiter FSM states (IDLE / CMD / WAIT / RESP)
//   - REQ_F/D/G   : requester bit positions inside the {g,d,f} request vector
//   - AW_DEF/DW_DEF : default address / data widths
//   - in_window() : inclusive address-range test used by write protection
// -----------------------------------------------------------------------------
package punc_mem_arb_pkg;

    localparam int AW_DEF  = 16;
    localparam int DW_DEF  = 16;

    localparam int REQ_F   = 0;
    localparam int REQ_D   = 1;
    localparam int REQ_G   = 2;
    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    // Addresses are zero-extended to 32 bits so the test works for any AW <= 32.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/punc_mem_arb_pick.sv
// -----------------------------------------------------------------------------
// punc_mem_arb_pick
// Combinational winner select for the memory arbiter.
// Fixed priority D > F > G, except that an aged-out G (i_age_hit) beats both.
// Ports:
//   i_req     [2:0]  request vector, bit positions REQ_F / REQ_D / REQ_G
//   i_age_hit        G has waited AGE_MAX arbitrations
//   o_win     [2:0]  one-hot winner, all zero when nothing is requested
// -----------------------------------------------------------------------------
module punc_mem_arb_pick
    import punc_mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_age_hit,
    output logic [NUM_REQ-1:0] o_win
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        o_win = '0;
        if (i_age_hit && i_req[REQ_G]) begin
            o_win[REQ_G] = 1'b1;
        end else if (i_req[REQ_D]) begin
            o_win[REQ_D] = 1'b1;
        end else if (i_req[REQ_F]) begin
            o_win[REQ_F] = 1'b1;
        end else if (i_req[REQ_G]) begin
            o_win[REQ_G] = 1'b1;
        end
    end

endmodule

// File: rtl/punc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// punc_mem_arbiter
// Shares the single-port LC3 memory between instruction fetch (F), data
// load/store (D) and the debug/loader port (G). One transaction in flight at a
// time; the winner is registered in IDLE, then CMD -> (WAIT) -> RESP.
//
// Optional feature (macro PUNC_MEM_ARB_PROTECT_EN): D writes that land in
// [PROT_BASE, PROT_LIMIT] are suppressed and flagged on err; without the macro
// err is tied low and the PROT_* parameters are unused.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   {f,d,g}_req/_we/_addr         requests (f_we ignored, F only reads)
//   {d,g}_wdata                   write data
//   {f,d,g}_gnt                   one-cycle accept pulse (CMD cycle)
//   {f,d,g}_rvalid, rdata         one-cycle read-data-valid pulse, shared data
//   mem_addr/_wr_en/_wdata/_rdata memory interface
//   busy                          high whenever the FSM is not IDLE
//   err                           protection-violation pulse
// -----------------------------------------------------------------------------
module punc_mem_arbiter
    import punc_mem_arb_pkg::*;
#(
    parameter int            AW         = AW_DEF,
    parameter int            DW         = DW_DEF,
    parameter int            RD_LAT     = 1,
    parameter int            AGE_MAX    = 15,
    parameter logic [AW-1:0] PROT_BASE  = '0,
    parameter logic [AW-1:0] PROT_LIMIT = AW'(16'h00FF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic          d_req,
    input  logic          g_req,
    input  logic          f_we,
    input  logic          d_we,
    input  logic          g_we,
    input  logic [AW-1:0] f_addr,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] g_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [DW-1:0] g_wdata,
    output logic          f_gnt,
    output logic          d_gnt,
    output logic          g_gnt,
    output logic          f_rvalid,
    output logic          d_rvalid,
    output logic          g_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          err
);

    // Index of the last WAIT cycle; only meaningful when RD_LAT > 0.
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [NUM_REQ-1:0]   r_owner;
    logic                 r_we;
    logic [AW-1:0]        r_addr;
    logic [DW-1:0]        r_wdata;
    logic [DW-1:0]        r_rdata;
    logic [7:0]           r_age;
    logic [2:0]           r_lat_cnt;

    logic [NUM_REQ-1:0]   w_req;
    logic [NUM_REQ-1:0]   w_win;
    logic                 w_any_req;
    logic                 w_age_hit;
    logic                 w_sel_we;
    logic [AW-1:0]        w_sel_addr;
    logic [DW-1:0]        w_sel_wdata;
    logic                 w_cmd;
    logic                 w_resp;
    logic                 w_last_wait;
    logic                 w_cap_rdata;
    logic                 w_prot_hit;
    logic                 w_unused;

    assign w_req     = {g_req, d_req, f_req};
    assign w_any_req = |w_req;
    assign w_age_hit = (r_age == 8'(AGE_MAX));

    punc_mem_arb_pick u_pick (
        .i_req     (w_req),
        .i_age_hit (w_age_hit),
        .o_win     (w_win)
    );

    // Fields of the winning requester, captured on the IDLE -> CMD edge.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = f_addr;
        w_sel_wdata = '0;
        if (w_win[REQ_D]) begin
            w_sel_we    = d_we;
            w_sel_addr  = d_addr;
            w_sel_wdata = d_wdata;
        end else if (w_win[REQ_G]) begin
            w_sel_we    = g_we;
            w_sel_addr  = g_addr;
            w_sel_wdata = g_wdata;
        end
    end

    assign w_cmd       = (r_state == CMD);
    assign w_resp      = (r_state == RESP);
    assign w_last_wait = (r_lat_cnt == LAT_LAST);

    // mem_rdata is valid RD_LAT cycles after the command cycle: that is the CMD
    // cycle itself for RD_LAT == 0, otherwise the last WAIT cycle.
    assign w_cap_rdata = (w_cmd && !r_we && (RD_LAT == 0)) ||
                         ((r_state == WAIT) && w_last_wait);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_any_req) w_state_nxt = CMD;
            CMD: begin
                if (r_we)             w_state_nxt = IDLE;
                else if (RD_LAT == 0) w_state_nxt = RESP;
                else                  w_state_nxt = WAIT;
            end
            WAIT: if (w_last_wait) w_state_nxt = RESP;
            RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner   <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_age     <= '0;
            r_lat_cnt <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (w_any_req) begin
                    r_owner <= w_win;
                    r_we    <= w_sel_we;
                    r_addr  <= w_sel_addr;
                    r_wdata <= w_sel_wdata;
                end
                // With g_req high, G either wins (clear) or someone else won.
                if (!g_req || w_win[REQ_G]) begin
                    r_age <= '0;
                end else if (!w_age_hit) begin
                    r_age <= r_age + 8'd1;
                end
            end

            if (w_cmd) begin
                r_lat_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_lat_cnt <= r_lat_cnt + 3'd1;
            end

            if (w_cap_rdata) begin
                r_rdata <= mem_rdata;
            end
        end
    end

`ifdef PUNC_MEM_ARB_PROTECT_EN
    assign w_prot_hit = w_cmd && r_we && r_owner[REQ_D] &&
                        in_window(32'(r_addr), 32'(PROT_BASE), 32'(PROT_LIMIT));
    assign w_unused   = f_we;
`else
    assign w_prot_hit = 1'b0;
    assign w_unused   = f_we ^ (^PROT_BASE) ^ (^PROT_LIMIT);
`endif

    assign f_gnt     = w_cmd  & r_owner[REQ_F];
    assign d_gnt     = w_cmd  & r_owner[REQ_D];
    assign g_gnt     = w_cmd  & r_owner[REQ_G];
    assign f_rvalid  = w_resp & r_owner[REQ_F];
    assign d_rvalid  = w_resp & r_owner[REQ_D];
    assign g_rvalid  = w_resp & r_owner[REQ_G];
    assign rdata     = r_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wr_en = w_cmd & r_we & ~w_prot_hit;
    assign err       = w_prot_hit;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_punc_mem_arbiter
// Scoreboard bench for punc_mem_arbiter. u_dut runs RD_LAT=1, AGE_MAX=3 against
// a registered memory model; u_dut_lat0 runs RD_LAT=0 against a combinational
// memory. Expected grants and read responses are queued when stimulus is
// driven and popped by a monitor on the falling edge.
// Honours PUNC_MEM_ARB_PROTECT_EN for the expected err / mem_wr_en values.
// -----------------------------------------------------------------------------
module tb_punc_mem_arbiter;
    import punc_mem_arb_pkg::*;

    typedef struct {
        int          who;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        wr;
        logic        err;
    } gnt_exp_t;

    typedef struct {
        int          who;
        logic [15:0] data;
    } rd_exp_t;

    logic clk;
    logic rst;

    logic        f_req, d_req, g_req, f_we, d_we, g_we;
    logic [15:0] f_addr, d_addr, g_addr, d_wdata, g_wdata;
    logic        f_gnt, d_gnt, g_gnt, f_rvalid, d_rvalid, g_rvalid;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr_en, busy, err;

    logic        b_f_req;
    logic [15:0] b_f_addr;
    logic        b_zero;
    logic [15:0] b_zero16;
    logic        b_f_gnt, b_d_gnt, b_g_gnt, b_f_rvalid, b_d_rvalid, b_g_rvalid;
    logic [15:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_wr_en, b_busy, b_err;

    logic [15:0] mem_a [logic [15:0]];

    gnt_exp_t gq[$];
    rd_exp_t  rq[$];
    gnt_exp_t mon_g;
    rd_exp_t  mon_r;

    int n_checks = 0;
    int n_errors = 0;

    punc_mem_arbiter #(.RD_LAT(1), .AGE_MAX(3)) u_dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .d_req(d_req), .g_req(g_req),
        .f_we(f_we), .d_we(d_we), .g_we(g_we),
        .f_addr(f_addr), .d_addr(d_addr), .g_addr(g_addr),
        .d_wdata(d_wdata), .g_wdata(g_wdata),
        .f_gnt(f_gnt), .d_gnt(d_gnt), .g_gnt(g_gnt),
        .f_rvalid(f_rvalid), .d_rvalid(d_rvalid), .g_rvalid(g_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    punc_mem_arbiter #(.RD_LAT(0)) u_dut_lat0 (
        .clk(clk), .rst(rst),
        .f_req(b_f_req), .d_req(b_zero), .g_req(b_zero),
        .f_we(b_zero), .d_we(b_zero), .g_we(b_zero),
        .f_addr(b_f_addr), .d_addr(b_zero16), .g_addr(b_zero16),
        .d_wdata(b_zero16), .g_wdata(b_zero16),
        .f_gnt(b_f_gnt), .d_gnt(b_d_gnt), .g_gnt(b_g_gnt),
        .f_rvalid(b_f_rvalid), .d_rvalid(b_d_rvalid), .g_rvalid(b_g_rvalid),
        .rdata(b_rdata), .mem_addr(b_mem_addr), .mem_wr_en(b_mem_wr_en),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem_a.exists(a) ? mem_a[a] : 16'h0000;
    endfunction

    // Memory model with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_wr_en) mem_a[mem_addr] = mem_wdata;
        mem_rdata <= mem_rd(mem_addr);
    end

    // Zero-latency memory for the second instance.
    assign b_mem_rdata = b_mem_addr ^ 16'h0BAD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int who_gnt();
        return f_gnt ? REQ_F : (d_gnt ? REQ_D : REQ_G);
    endfunction

    function automatic int who_rv();
        return f_rvalid ? REQ_F : (d_rvalid ? REQ_D : REQ_G);
    endfunction

    function automatic logic gnt_of(input int who);
        return (who == REQ_F) ? f_gnt : ((who == REQ_D) ? d_gnt : g_gnt);
    endfunction

    function automatic logic rvalid_of(input int who);
        return (who == REQ_F) ? f_rvalid : ((who == REQ_D) ? d_rvalid : g_rvalid);
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (f_gnt | d_gnt | g_gnt) begin
                check("gnt_onehot", $countones({f_gnt, d_gnt, g_gnt}), 1);
                check("gnt_expected", gq.size() != 0, 1);
                if (gq.size() != 0) begin
                    mon_g = gq.pop_front();
                    check("gnt_who", who_gnt(), mon_g.who);
                    check("gnt_addr", mem_addr, mon_g.addr);
                    check("gnt_wr_en", mem_wr_en, mon_g.wr);
                    check("gnt_err", err, mon_g.err);
                    if (mon_g.wr) check("gnt_wdata", mem_wdata, mon_g.wdata);
                end
            end else begin
                check("strobe_idle", {mem_wr_en, err}, 0);
            end
            if (f_rvalid | d_rvalid | g_rvalid) begin
                check("rv_onehot", $countones({f_rvalid, d_rvalid, g_rvalid}), 1);
                check("rv_expected", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    mon_r = rq.pop_front();
                    check("rv_who", who_rv(), mon_r.who);
                    check("rv_rdata", rdata, mon_r.data);
                end
            end
        end
    end

    task automatic drive_req(input int who, input logic req, input logic we,
                             input logic [15:0] addr, input logic [15:0] wdata);
        case (who)
            REQ_F: begin f_req = req; f_we = we; f_addr = addr; end
            REQ_D: begin d_req = req; d_we = we; d_addr = addr; d_wdata = wdata; end
            default: begin g_req = req; g_we = we; g_addr = addr; g_wdata = wdata; end
        endcase
    endtask

    task automatic wait_ev(input string tag, input bit rv, input int who,
                           input int max, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < max) begin
            @(negedge clk);
            cyc++;
            hit = rv ? rvalid_of(who) : gnt_of(who);
        end
        check({tag, "_seen"}, hit, 1);
    endtask

    task automatic req_txn(input int who, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, output int cyc);
        drive_req(who, 1'b1, we, addr, wdata);
        wait_ev("txn_gnt", 1'b0, who, 40, cyc);
        drive_req(who, 1'b0, 1'b0, addr, wdata);
    endtask

    task automatic push_g(input int who, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic wr, input logic e);
        gq.push_back('{who: who, addr: addr, wdata: wdata, wr: wr, err: e});
    endtask

    task automatic push_r(input int who, input logic [15:0] data);
        rq.push_back('{who: who, data: data});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((gq.size() != 0 || rq.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, gq.size() + rq.size(), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int c0, c1, c2, dwins;
        bit got_g;

        f_req = 0; d_req = 0; g_req = 0; f_we = 0; d_we = 0; g_we = 0;
        f_addr = 0; d_addr = 0; g_addr = 0; d_wdata = 0; g_wdata = 0;
        b_f_req = 0; b_f_addr = 0; b_zero = 0; b_zero16 = 0;
        mem_a[16'h3000] = 16'hBEEF;
        mem_a[16'h0200] = 16'hA5A5;

        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {f_gnt, d_gnt, g_gnt, f_rvalid, d_rvalid, g_rvalid,
                           mem_wr_en, err, busy}, 0);
        check("rst_data", {mem_addr, mem_wdata}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_b_ctrl", {b_f_gnt, b_f_rvalid, b_mem_wr_en, b_err, b_busy}, 0);
        rst = 1'b1;

        // D read, RD_LAT=1: gnt N+1, rvalid N+3, busy N+1..N+3.
        @(negedge clk);
        push_g(REQ_D, 16'h3000, 16'h0, 1'b0, 1'b0);
        push_r(REQ_D, 16'hBEEF);
        req_txn(REQ_D, 1'b0, 16'h3000, 16'h0, c0);
        check("rd_gnt_lat", c0, 1);
        check("rd_busy_cmd", busy, 1);
        @(negedge clk);
        check("rd_busy_wait", {busy, d_rvalid}, 2'b10);
        @(negedge clk);
        check("rd_rvalid_n3", {busy, d_rvalid}, 2'b11);
        @(negedge clk);
        check("rd_idle_after", {busy, d_rvalid}, 2'b00);

        // Simultaneous F read, D write, G read of D's location: order D, F, G.
        push_g(REQ_D, 16'h3001, 16'h1234, 1'b1, 1'b0);
        push_g(REQ_F, 16'h0200, 16'h0, 1'b0, 1'b0);
        push_g(REQ_G, 16'h3001, 16'h0, 1'b0, 1'b0);
        push_r(REQ_F, 16'hA5A5);
        push_r(REQ_G, 16'h1234);
        fork
            req_txn(REQ_D, 1'b1, 16'h3001, 16'h1234, c0);
            req_txn(REQ_F, 1'b0, 16'h0200, 16'h0, c1);
            req_txn(REQ_G, 1'b0, 16'h3001, 16'h0, c2);
        join
        check("pri_d_first", c0, 1);
        check("pri_f_after_write", c1, 3);
        drain("pri");

        // Aging: D writes back to back, G held -> D, D, D, then G.
        for (int i = 0; i < 3; i++) push_g(REQ_D, 16'h4000, 16'h5555, 1'b1, 1'b0);
        push_g(REQ_G, 16'h4000, 16'h0, 1'b0, 1'b0);
        push_r(REQ_G, 16'h5555);
        drive_req(REQ_D, 1'b1, 1'b1, 16'h4000, 16'h5555);
        drive_req(REQ_G, 1'b1, 1'b0, 16'h4000, 16'h0);
        dwins = 0;
        got_g = 1'b0;
        for (int n = 0; n < 40 && !got_g; n++) begin
            @(negedge clk);
            if (d_gnt) dwins++;
            if (g_gnt) begin
                got_g = 1'b1;
                drive_req(REQ_D, 1'b0, 1'b0, 16'h0, 16'h0);
                drive_req(REQ_G, 1'b0, 1'b0, 16'h0, 16'h0);
            end
        end
        check("age_g_seen", got_g, 1);
        check("age_d_wins", dwins, 3);
        drain("age");

        // Age cleared: D and G together -> D first again.
        push_g(REQ_D, 16'h3000, 16'h0, 1'b0, 1'b0);
        push_g(REQ_G, 16'h3001, 16'h0, 1'b0, 1'b0);
        push_r(REQ_D, 16'hBEEF);
        push_r(REQ_G, 16'h1234);
        fork
            req_txn(REQ_D, 1'b0, 16'h3000, 16'h0, c0);
            req_txn(REQ_G, 1'b0, 16'h3001, 16'h0, c1);
        join
        check("age_clr_d_first", c0, 1);
        drain("age_clr");

        // Reset during WAIT of an F read; F stays requested throughout.
        push_g(REQ_F, 16'h0200, 16'h0, 1'b0, 1'b0);
        drive_req(REQ_F, 1'b1, 1'b0, 16'h0200, 16'h0);
        wait_ev("rst_first_gnt", 1'b0, REQ_F, 10, c0);
        @(negedge clk);
        check("rst_in_wait", busy, 1);
        rst = 1'b0;
        #1;
        check("rst_mid_ctrl", {f_gnt, d_gnt, g_gnt, f_rvalid, d_rvalid, g_rvalid,
                               mem_wr_en, err, busy}, 0);
        check("rst_mid_data", {mem_addr, mem_wdata}, 0);
        check("rst_mid_rdata", rdata, 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("rst_hold_quiet", {f_gnt, f_rvalid, busy}, 0);
        end
        push_g(REQ_F, 16'h0200, 16'h0, 1'b0, 1'b0);
        push_r(REQ_F, 16'hA5A5);
        rst = 1'b1;
        wait_ev("rst_regrant", 1'b0, REQ_F, 10, c0);
        check("rst_regrant_lat", c0, 1);
        drive_req(REQ_F, 1'b0, 1'b0, 16'h0, 16'h0);
        drain("rst");

        // Protected window: D write suppressed when the feature is built in;
        // G write to the same address always goes through.
`ifdef PUNC_MEM_ARB_PROTECT_EN
        push_g(REQ_D, 16'h0080, 16'h7777, 1'b0, 1'b1);
`else
        push_g(REQ_D, 16'h0080, 16'h7777, 1'b1, 1'b0);
`endif
        req_txn(REQ_D, 1'b1, 16'h0080, 16'h7777, c0);
        drain("prot_d");
        push_g(REQ_G, 16'h0080, 16'h8888, 1'b1, 1'b0);
        req_txn(REQ_G, 1'b1, 16'h0080, 16'h8888, c0);
        drain("prot_g");

        // RD_LAT=0: F read of 0x0000 held -> gnt N+1, rvalid N+2, re-gnt N+4.
        @(negedge clk);
        b_f_req  = 1'b1;
        b_f_addr = 16'h0000;
        @(negedge clk);
        check("lat0_gnt_n1", {b_f_gnt, b_busy}, 2'b11);
        @(negedge clk);
        check("lat0_rvalid_n2", {b_f_rvalid, b_f_gnt}, 2'b10);
        check("lat0_rdata", b_rdata, 16'h0BAD);
        @(negedge clk);
        check("lat0_arb_n3", {b_busy, b_f_gnt, b_f_rvalid}, 0);
        @(negedge clk);
        check("lat0_regnt_n4", b_f_gnt, 1);
        b_f_req = 1'b0;
        @(negedge clk);
        check("lat0_rvalid2", b_f_rvalid, 1);
        @(negedge clk);
        check("lat0_idle", {b_busy, b_mem_wr_en, b_err}, 0);

        check("end_gq_empty", gq.size(), 0);
        check("end_rq_empty", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
